excp_ctrl: RTL and testbench
============================

# excp_ctrl

Exception/interrupt controller sitting at the MEM stage of the five-stage OpenMIPS pipeline, on the consuming side of the CP0 register block. It reads CP0 Status/Cause/EPC and applies WB-stage forwarding of pending `mtc0` writes. It decides whether the instruction in MEM takes an interrupt, exception or `eret`. It then issues the commit strobe back to CP0 and a registered pipeline flush with redirect PC.

## Interface
- EXC_VECTOR, 32'h00000020: redirect PC for all interrupts/exceptions.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- mem_valid_i  in  1  MEM holds a real instruction (0 = bubble).
- mem_pc_i  in  32  PC of MEM instruction.
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot.
- mem_excp_flags_i  in  32  one-hot-ish flags: bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret.
- cp0_status_i / cp0_cause_i / cp0_epc_i  in  32 each  current CP0 register outputs.
- wb_cp0_we_i  in  1, wb_cp0_waddr_i  in  5, wb_cp0_data_i  in  32  pending CP0 write in WB.
- mem_kill_o  out  1  combinational; suppresses the MEM instruction's reg/mem write.
- excp_valid_o  out  1  registered one-cycle commit strobe to CP0.
- excp_code_o  out  32  registered exception type for CP0.
- excp_pc_o  out  32  registered; excp_delayslot_o  out  1  registered.
- flush_o  out  1  registered one-cycle pipeline flush.
- new_pc_o  out  32  registered redirect PC.

## Operation
- Forwarding: Status is `wb_cp0_data_i` when `wb_cp0_we_i` and addr 12, else `cp0_status_i`. EPC is WB data when addr 14. Cause bits [9:8] come from WB data when addr 13; all other Cause bits come from `cp0_cause_i`.
- Interrupt pending: Status[0] (IE) is 1, Status[1] (EXL) is 0, and (Cause[15:8] & Status[15:8]) is nonzero.
- Evaluation happens only when state is IDLE and `mem_valid_i` is 1. Otherwise nothing is taken. A pending interrupt stays level-pending until a valid instruction reaches MEM.
- Priority and code: interrupt 32'h1, then syscall 32'h8, invalid 32'ha, trap 32'hd, overflow 32'hc, eret 32'he.
- Redirect: `eret` uses the forwarded EPC; every other code uses EXC_VECTOR.
- Take: `mem_kill_o` is 1 in the same cycle. Code, `mem_pc_i` and `mem_in_delayslot_i` are registered to the outputs. `excp_valid_o`, `flush_o` and `new_pc_o` are registered. CP0 is responsible for EPC adjustment on delay slots and for setting or clearing EXL.
- FSM IDLE: a take moves the FSM to FLUSH; otherwise it stays in IDLE.
- FSM FLUSH: lasts exactly one cycle with no evaluation, because the instruction in MEM is being flushed. It then returns to IDLE.
- `mem_kill_o` is 0 in FLUSH.
- Reset: state IDLE. All registered outputs are 0: `excp_valid_o`, `flush_o`, `excp_code_o`, `excp_pc_o`, `excp_delayslot_o`, `new_pc_o`. `rst` mid-FLUSH aborts to IDLE with outputs 0.

## Timing
- Cycle N: instruction with an event in MEM, state IDLE, so `mem_kill_o` is 1.
- Cycle N+1: `excp_valid_o`, `flush_o` and `new_pc_o` are valid for exactly one cycle, and state is FLUSH.
- Cycle N+2: state IDLE, evaluation resumes.
- Back-to-back events in N and N+1: only N is taken. The N+1 instruction is flushed and never reported.
- A `mtc0` in WB during cycle N is visible to the decision in N via forwarding, with zero bubble.
- Outputs do not depend on `mem_excp_flags_i` during FLUSH.

## Structure
- Shared package `excp_pkg` holds:
  - flag bit indices 8..12;
  - codes EXCP_INT/SYSCALL/INV/TRAP/OV/ERET;
  - CP0 addresses 12/13/14;
  - the FSM state enum.
- One natural sub-module, `excp_prio_enc`: a combinational priority encoder from interrupt-pending plus flags to code and take.

## Test plan
- Syscall: Status=32'h1000ff01, flags bit8, pc 32'h100 -> `mem_kill_o`=1 in N. In N+1: `excp_code_o`=32'h8, `excp_pc_o`=32'h100, `new_pc_o`=32'h20, `flush_o` pulse of 1 cycle.
- Interrupt masked/unmasked:
  - Cause[10]=1, Status=32'h0000ff01 -> code 32'h1 taken on the next valid instruction.
  - Same case with Status[1]=1 (EXL), or with `mem_valid_i`=0 bubbles -> no take until a valid instruction arrives with EXL clear.
- Forwarding: `cp0_epc_i`=32'h40, WB writes addr 14 with 32'h80, eret flag -> `new_pc_o`=32'h80, code 32'he.
- Priority: interrupt pending plus overflow flag in the same cycle -> code 32'h1 only. Overflow alone with delay slot set -> code 32'hc, `excp_delayslot_o`=1.
- Back-to-back: trap in N, syscall in N+1 -> a single `excp_valid_o` pulse (code 32'hd). Syscall at N+2 -> second pulse at N+3.
- Reset mid-operation: `rst` asserted in the FLUSH cycle -> next cycle all outputs 0, state IDLE, and a fresh syscall is taken normally.

Source files
------------

// File: rtl/excp_pkg.sv
// Shared definitions for the MEM-stage exception controller: flag positions,
// exception codes, CP0 register addresses and the controller FSM states.
package excp_pkg;

  localparam int FLAG_SYSCALL = 8;
  localparam int FLAG_INV     = 9;
  localparam int FLAG_TRAP    = 10;
  localparam int FLAG_OV      = 11;
  localparam int FLAG_ERET    = 12;

  localparam logic [31:0] EXCP_INT     = 32'h0000_0001;
  localparam logic [31:0] EXCP_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXCP_INV     = 32'h0000_000a;
  localparam logic [31:0] EXCP_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXCP_OV      = 32'h0000_000c;
  localparam logic [31:0] EXCP_ERET    = 32'h0000_000e;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/excp_prio_enc.sv
// Fixed-priority encoder: interrupt first, then the MEM-stage exception flags.
module excp_prio_enc
  import excp_pkg::*;
(
  input  logic        int_pend,
  input  logic [4:0]  flags,
  output logic        take,
  output logic        is_eret,
  output logic [31:0] code
);

  // flags[k] corresponds to instruction flag bit (k + FLAG_SYSCALL)
  always_comb begin
    take    = 1'b1;
    is_eret = 1'b0;
    code    = '0;
    if (int_pend) begin
      code = EXCP_INT;
    end else if (flags[FLAG_SYSCALL - FLAG_SYSCALL]) begin
      code = EXCP_SYSCALL;
    end else if (flags[FLAG_INV - FLAG_SYSCALL]) begin
      code = EXCP_INV;
    end else if (flags[FLAG_TRAP - FLAG_SYSCALL]) begin
      code = EXCP_TRAP;
    end else if (flags[FLAG_OV - FLAG_SYSCALL]) begin
      code = EXCP_OV;
    end else if (flags[FLAG_ERET - FLAG_SYSCALL]) begin
      code    = EXCP_ERET;
      is_eret = 1'b1;
    end else begin
      take = 1'b0;
    end
  end

endmodule

// File: rtl/excp_ctrl.sv
// MEM-stage exception/interrupt controller: forwards pending CP0 writes, picks
// the event to take, and issues a registered commit strobe, flush and redirect.
module excp_ctrl
  import excp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic [DATA_W-1:0] mem_pc_i,
  input  logic              mem_in_delayslot_i,
  input  logic [DATA_W-1:0] mem_excp_flags_i,
  input  logic [DATA_W-1:0] cp0_status_i,
  input  logic [DATA_W-1:0] cp0_cause_i,
  input  logic [DATA_W-1:0] cp0_epc_i,
  input  logic              wb_cp0_we_i,
  input  logic [4:0]        wb_cp0_waddr_i,
  input  logic [DATA_W-1:0] wb_cp0_data_i,
  output logic              mem_kill_o,
  output logic              excp_valid_o,
  output logic [DATA_W-1:0] excp_code_o,
  output logic [DATA_W-1:0] excp_pc_o,
  output logic              excp_delayslot_o,
  output logic              flush_o,
  output logic [DATA_W-1:0] new_pc_o
);

  state_t state, state_nxt;

  logic [DATA_W-1:0] status_fwd, cause_fwd, epc_fwd;
  logic              int_pend;
  logic              enc_take, enc_eret;
  logic [31:0]       enc_code;
  logic              take;
  logic              unused_bits;

  always_comb begin
    status_fwd = cp0_status_i;
    epc_fwd    = cp0_epc_i;
    cause_fwd  = cp0_cause_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) status_fwd = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC)    epc_fwd    = wb_cp0_data_i;
    // Only the software-interrupt bits of Cause are writable by mtc0
    if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE)  cause_fwd[9:8] = wb_cp0_data_i[9:8];
  end

  assign int_pend = status_fwd[0] && !status_fwd[1] &&
                    ((cause_fwd[15:8] & status_fwd[15:8]) != 8'd0);

  excp_prio_enc u_prio_enc (
    .int_pend (int_pend),
    .flags    (mem_excp_flags_i[FLAG_ERET:FLAG_SYSCALL]),
    .take     (enc_take),
    .is_eret  (enc_eret),
    .code     (enc_code)
  );

  assign take       = (state == ST_IDLE) && mem_valid_i && enc_take;
  assign mem_kill_o = take;

  assign unused_bits = ^{mem_excp_flags_i[DATA_W-1:FLAG_ERET+1],
                         mem_excp_flags_i[FLAG_SYSCALL-1:0],
                         status_fwd[DATA_W-1:16], status_fwd[7:2],
                         cause_fwd[DATA_W-1:16], cause_fwd[7:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (take) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: registered commit strobe, exception record, flush and redirect
  logic              vld_p1, flush_p1, ds_p1;
  logic [DATA_W-1:0] code_p1, pc_p1, new_pc_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      vld_p1    <= 1'b0;
      flush_p1  <= 1'b0;
      ds_p1     <= 1'b0;
      code_p1   <= '0;
      pc_p1     <= '0;
      new_pc_p1 <= '0;
    end else begin
      state    <= state_nxt;
      vld_p1   <= take;
      flush_p1 <= take;
      if (take) begin
        ds_p1     <= mem_in_delayslot_i;
        code_p1   <= DATA_W'(enc_code);
        pc_p1     <= mem_pc_i;
        new_pc_p1 <= enc_eret ? epc_fwd : DATA_W'(EXC_VECTOR);
      end
    end
  end

  assign excp_valid_o     = vld_p1;
  assign flush_o          = flush_p1;
  assign excp_delayslot_o = ds_p1;
  assign excp_code_o      = code_p1;
  assign excp_pc_o        = pc_p1;
  assign new_pc_o         = new_pc_p1;

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed testbench for excp_ctrl: one task per scenario, inline checks.
module tb_excp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [31:0] mem_excp_flags_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic        mem_kill_o, excp_valid_o, excp_delayslot_o, flush_o;
  logic [31:0] excp_code_o, excp_pc_o, new_pc_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  excp_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_i        (mem_valid_i),
    .mem_pc_i           (mem_pc_i),
    .mem_in_delayslot_i (mem_in_delayslot_i),
    .mem_excp_flags_i   (mem_excp_flags_i),
    .cp0_status_i       (cp0_status_i),
    .cp0_cause_i        (cp0_cause_i),
    .cp0_epc_i          (cp0_epc_i),
    .wb_cp0_we_i        (wb_cp0_we_i),
    .wb_cp0_waddr_i     (wb_cp0_waddr_i),
    .wb_cp0_data_i      (wb_cp0_data_i),
    .mem_kill_o         (mem_kill_o),
    .excp_valid_o       (excp_valid_o),
    .excp_code_o        (excp_code_o),
    .excp_pc_o          (excp_pc_o),
    .excp_delayslot_o   (excp_delayslot_o),
    .flush_o            (flush_o),
    .new_pc_o           (new_pc_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid_i        = 1'b0;
    mem_pc_i           = 32'h0;
    mem_in_delayslot_i = 1'b0;
    mem_excp_flags_i   = 32'h0;
    cp0_status_i       = 32'h0;
    cp0_cause_i        = 32'h0;
    cp0_epc_i          = 32'h0;
    wb_cp0_we_i        = 1'b0;
    wb_cp0_waddr_i     = 5'd0;
    wb_cp0_data_i      = 32'h0;
  endtask

  task automatic drive_inst(input logic [31:0] pc, input logic [31:0] flags, input logic ds);
    mem_valid_i        = 1'b1;
    mem_pc_i           = pc;
    mem_excp_flags_i   = flags;
    mem_in_delayslot_i = ds;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({excp_valid_o, flush_o, excp_delayslot_o} !== 3'b000 || excp_code_o !== 32'h0 ||
        excp_pc_o !== 32'h0 || new_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b flush=%b ds=%b code=%h pc=%h npc=%h required all zero",
               excp_valid_o, flush_o, excp_delayslot_o, excp_code_o, excp_pc_o, new_pc_o);
    end
    rst = 1'b0;
    checks++;
    if (mem_kill_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_kill: got %b required 0", mem_kill_o);
    end
  endtask

  task automatic test_syscall();
    idle_inputs();
    cp0_status_i = 32'h1000ff01;
    drive_inst(32'h100, 32'h100, 1'b0);
    #1;
    checks++;
    if (mem_kill_o !== 1'b1) begin
      errors++;
      $display("FAIL syscall_kill: got %b required 1", mem_kill_o);
    end
    tick();
    mem_valid_i = 1'b0;
    checks++;
    if (excp_valid_o !== 1'b1 || flush_o !== 1'b1 || excp_code_o !== 32'h8 ||
        excp_pc_o !== 32'h100 || new_pc_o !== 32'h20) begin
      errors++;
      $display("FAIL syscall_take: valid=%b flush=%b code=%h pc=%h npc=%h required 1 1 8 100 20",
               excp_valid_o, flush_o, excp_code_o, excp_pc_o, new_pc_o);
    end
    tick();
    checks++;
    if (excp_valid_o !== 1'b0 || flush_o !== 1'b0) begin
      errors++;
      $display("FAIL syscall_pulse_width: valid=%b flush=%b required 0 0", excp_valid_o, flush_o);
    end
  endtask

  task automatic test_interrupt();
    idle_inputs();
    cp0_cause_i  = 32'h0000_0400;
    cp0_status_i = 32'h0000ff01;
    tick();
    tick();
    checks++;
    if (excp_valid_o !== 1'b0 || mem_kill_o !== 1'b0) begin
      errors++;
      $display("FAIL int_bubble: valid=%b kill=%b required 0 0", excp_valid_o, mem_kill_o);
    end
    cp0_status_i = 32'h0000ff03;
    drive_inst(32'h110, 32'h0, 1'b0);
    #1;
    checks++;
    if (mem_kill_o !== 1'b0) begin
      errors++;
      $display("FAIL int_exl_kill: got %b required 0", mem_kill_o);
    end
    tick();
    checks++;
    if (excp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL int_exl_take: got %b required 0", excp_valid_o);
    end
    cp0_status_i = 32'h0000ff01;
    drive_inst(32'h114, 32'h0, 1'b0);
    #1;
    checks++;
    if (mem_kill_o !== 1'b1) begin
      errors++;
      $display("FAIL int_kill: got %b required 1", mem_kill_o);
    end
    tick();
    mem_valid_i = 1'b0;
    checks++;
    if (excp_valid_o !== 1'b1 || excp_code_o !== 32'h1 || excp_pc_o !== 32'h114 ||
        new_pc_o !== 32'h20) begin
      errors++;
      $display("FAIL int_take: valid=%b code=%h pc=%h npc=%h required 1 1 114 20",
               excp_valid_o, excp_code_o, excp_pc_o, new_pc_o);
    end
    tick();
  endtask

  task automatic test_forwarding();
    idle_inputs();
    cp0_epc_i      = 32'h40;
    wb_cp0_we_i    = 1'b1;
    wb_cp0_waddr_i = 5'd14;
    wb_cp0_data_i  = 32'h80;
    drive_inst(32'h120, 32'h1000, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (excp_valid_o !== 1'b1 || excp_code_o !== 32'he || new_pc_o !== 32'h80) begin
      errors++;
      $display("FAIL fwd_epc: valid=%b code=%h npc=%h required 1 e 80",
               excp_valid_o, excp_code_o, new_pc_o);
    end
    tick();
    // Status written in WB enables an interrupt that CP0 would still mask
    cp0_cause_i    = 32'h0000_0400;
    wb_cp0_we_i    = 1'b1;
    wb_cp0_waddr_i = 5'd12;
    wb_cp0_data_i  = 32'h0000ff01;
    drive_inst(32'h130, 32'h0, 1'b0);
    #1;
    checks++;
    if (mem_kill_o !== 1'b1) begin
      errors++;
      $display("FAIL fwd_status_kill: got %b required 1", mem_kill_o);
    end
    tick();
    idle_inputs();
    checks++;
    if (excp_code_o !== 32'h1 || excp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL fwd_status_take: code=%h valid=%b required 1 1", excp_code_o, excp_valid_o);
    end
    tick();
    // Cause[9:8] written in WB raises a software interrupt
    cp0_status_i   = 32'h0000ff01;
    wb_cp0_we_i    = 1'b1;
    wb_cp0_waddr_i = 5'd13;
    wb_cp0_data_i  = 32'h0000_0100;
    drive_inst(32'h140, 32'h0, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (excp_code_o !== 32'h1 || excp_valid_o !== 1'b1 || excp_pc_o !== 32'h140) begin
      errors++;
      $display("FAIL fwd_cause: code=%h valid=%b pc=%h required 1 1 140",
               excp_code_o, excp_valid_o, excp_pc_o);
    end
    tick();
    // WB data to an unrelated address must not forward into Cause
    cp0_status_i   = 32'h0000ff01;
    wb_cp0_we_i    = 1'b1;
    wb_cp0_waddr_i = 5'd11;
    wb_cp0_data_i  = 32'h0000_0300;
    drive_inst(32'h144, 32'h0, 1'b0);
    #1;
    checks++;
    if (mem_kill_o !== 1'b0) begin
      errors++;
      $display("FAIL fwd_wrong_addr: kill=%b required 0", mem_kill_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_priority();
    idle_inputs();
    cp0_status_i = 32'h0000ff01;
    cp0_cause_i  = 32'h0000_0400;
    drive_inst(32'h150, 32'h800, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (excp_code_o !== 32'h1 || excp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL prio_int_over_ov: code=%h valid=%b required 1 1", excp_code_o, excp_valid_o);
    end
    tick();
    drive_inst(32'h160, 32'h800, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (excp_code_o !== 32'hc || excp_delayslot_o !== 1'b1 || excp_pc_o !== 32'h160 ||
        new_pc_o !== 32'h20) begin
      errors++;
      $display("FAIL prio_ov_ds: code=%h ds=%b pc=%h npc=%h required c 1 160 20",
               excp_code_o, excp_delayslot_o, excp_pc_o, new_pc_o);
    end
    tick();
    drive_inst(32'h170, 32'h600, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (excp_code_o !== 32'ha) begin
      errors++;
      $display("FAIL prio_inv_over_trap: code=%h required a", excp_code_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    drive_inst(32'h200, 32'h400, 1'b0);
    tick();
    drive_inst(32'h204, 32'h100, 1'b0);
    #1;
    checks++;
    if (mem_kill_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_flush_kill: got %b required 0", mem_kill_o);
    end
    checks++;
    if (excp_valid_o !== 1'b1 || excp_code_o !== 32'hd || excp_pc_o !== 32'h200) begin
      errors++;
      $display("FAIL b2b_first: valid=%b code=%h pc=%h required 1 d 200",
               excp_valid_o, excp_code_o, excp_pc_o);
    end
    tick();
    checks++;
    if (excp_valid_o !== 1'b0 || flush_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_second: valid=%b flush=%b required 0 0", excp_valid_o, flush_o);
    end
    drive_inst(32'h208, 32'h100, 1'b0);
    #1;
    checks++;
    if (mem_kill_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_resume_kill: got %b required 1", mem_kill_o);
    end
    tick();
    idle_inputs();
    checks++;
    if (excp_valid_o !== 1'b1 || excp_code_o !== 32'h8 || excp_pc_o !== 32'h208) begin
      errors++;
      $display("FAIL b2b_second_pulse: valid=%b code=%h pc=%h required 1 8 208",
               excp_valid_o, excp_code_o, excp_pc_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    drive_inst(32'h2f0, 32'h400, 1'b1);
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({excp_valid_o, flush_o, excp_delayslot_o} !== 3'b000 || excp_code_o !== 32'h0 ||
        excp_pc_o !== 32'h0 || new_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: valid=%b flush=%b ds=%b code=%h pc=%h npc=%h required all zero",
               excp_valid_o, flush_o, excp_delayslot_o, excp_code_o, excp_pc_o, new_pc_o);
    end
    drive_inst(32'h300, 32'h100, 1'b0);
    #1;
    checks++;
    if (mem_kill_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_kill: got %b required 1", mem_kill_o);
    end
    tick();
    idle_inputs();
    checks++;
    if (excp_valid_o !== 1'b1 || excp_code_o !== 32'h8 || excp_pc_o !== 32'h300 ||
        flush_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_retake: valid=%b code=%h pc=%h flush=%b required 1 8 300 1",
               excp_valid_o, excp_code_o, excp_pc_o, flush_o);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_syscall();
    test_interrupt();
    test_forwarding();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
